// File: rtl/alu_result_fifo.sv
// alu_result_fifo: output buffer for the 2-stage ALU.
// Every valid_i pulse delivers one DATA_WIDTH+1 bit result (carry/borrow in
// the MSB). The upstream ALU cannot be stalled, so results are captured into
// a first-word-fall-through FIFO. A result that arrives with no free slot is
// dropped, and the sticky overflow_o flag records the loss.
//
// Handshake contract on the consumer side: valid_o/data_o describe the head
// entry; a transfer happens on every rising edge where valid_o=1 and
// ready_i=1. valid_o never depends combinationally on ready_i, and
// data_o is held stable while valid_o=1 and ready_i=0. ready_i while
// valid_o=0 is ignored.
//
// DEPTH must be a power of two (>= 2) and ADDR_WIDTH must equal log2(DEPTH);
// pointers rely on natural binary wrap.
module alu_result_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH:0]   data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH:0]   data_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  overflow_o,
    input  logic                  clr_ovf_i
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_COUNT  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_PTR  = ADDR_WIDTH'(1);

    // Storage is deliberately left without reset; valid_o gates its use.
    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;

    logic push;
    logic pop;
    logic drop;

    // Transfer decode: a full FIFO still accepts a result if the head leaves
    // in the same cycle, because the freed slot is reused at that edge.
    always_comb begin
        pop  = valid_o & ready_i;
        push = valid_i & (~full_o | pop);
        drop = valid_i & full_o & ~pop;
    end

    // Status decode from the registered occupancy count.
    always_comb begin
        count_o    = count;
        full_o     = (count == FULL_COUNT);
        empty_o    = (count == '0);
        valid_o    = ~empty_o;
        overflow_o = overflow;
    end

    // Head entry, forced to zero when nothing is stored.
    always_comb begin
        data_o = '0;
        if (valid_o) begin
            data_o = mem[rd_ptr];
        end
    end

    // Result storage write; inputs are ignored while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Write pointer advances on each accepted result.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + ONE_PTR;
        end
    end

    // Read pointer advances on each consumer transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + ONE_PTR;
        end
    end

    // Occupancy: simultaneous push and pop cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + ONE_COUNT;
                2'b01:   count <= count - ONE_COUNT;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf_i) begin
            overflow <= 1'b0;
        end
    end

endmodule
